// File: rtl/mult_pkg.sv
// Shared definitions for the multiply/accumulate datapath: product width and
// the accumulator FSM state encoding.
package mult_pkg;

  localparam int PROD_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/prod_accumulator_if.sv
// Burst-control, product-input and result-output handshakes of the product
// accumulator. The master modport drives bursts; the slave modport is the accumulator.
interface prod_accumulator_if
  import mult_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEFAULT,
  parameter int ACC_W  = 12,
  parameter int LEN_W  = 4
) ();

  logic              start;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;
  logic              busy;

  modport master (
    output start, len, in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport slave (
    input  start, len, in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );

endinterface

// File: rtl/prod_accumulator.sv
// Sums a programmed-length burst of unsigned products into an ACC_W-bit
// accumulator with a sticky carry-out flag, then holds the result until taken.
module prod_accumulator
  import mult_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEFAULT,
  parameter int ACC_W  = 12,   // must be >= PROD_W
  parameter int LEN_W  = 4
) (
  input logic                clk,
  input logic                rst,
  prod_accumulator_if.slave  bus
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W:0]     sum_ext;
  logic               xfer;

  // One extra bit captures the carry out of the ACC_W-bit add.
  assign sum_ext = {1'b0, acc_q} + (ACC_W + 1)'(bus.in_prod);
  assign xfer    = (state_q == ST_ACC) && bus.in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = bus.len;
          state_d = (bus.len == '0) ? ST_HOLD : ST_ACC;
        end
      end
      ST_ACC: begin
        if (xfer) begin
          acc_d = sum_ext[ACC_W-1:0];
          ovf_d = ovf_q | sum_ext[ACC_W];
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Result outputs come straight from registers, so they persist through IDLE.
  assign bus.in_ready  = (state_q == ST_ACC);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_sum   = acc_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: doc/prod_accumulator.md
Name: prod_accumulator

Overview:
- Downstream consumer of the 4x4 combinational multiplier's 8-bit products.
- Accepts a programmed-length burst of products over a valid/ready handshake and sums them into a wider accumulator.
- Presents the final sum and a sticky overflow flag on an output valid/ready handshake.
- Forms the accumulate half of a dot-product / MAC datapath; one sequential FSM, one clock domain.

Parameters:
- PROD_W, 8, width of each incoming product (matches multiplier output).
- ACC_W, 12, accumulator and result width; must be >= PROD_W.
- LEN_W, 4, width of the burst-length field (max burst 2^LEN_W - 1 products).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a burst; sampled only in IDLE.
- len  in  LEN_W  number of products in the burst; sampled with start.
- in_valid  in  1  in_prod is valid.
- in_ready  out  1  block accepts in_prod this cycle.
- in_prod  in  PROD_W  unsigned product from the multiplier.
- out_valid  out  1  out_sum/out_ovf are valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  accumulated sum, modulo 2^ACC_W.
- out_ovf  out  1  sticky: some addition in this burst carried out of ACC_W.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: synchronous on rst=1 at a clk edge. State=IDLE, acc=0, cnt=0, ovf=0. Outputs: in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
- rst overrides every other input, including mid-burst; a partial burst is discarded.
- States: IDLE, ACC, HOLD.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start=1: acc<=0, ovf<=0, cnt<=len.
  - If len==0, go to HOLD (empty burst, sum 0). Otherwise go to ACC.
- ACC:
  - in_ready=1 combinationally from state. A transfer occurs on in_valid & in_ready.
  - On transfer: acc<=(acc+zero-extended in_prod) mod 2^ACC_W, and ovf<=ovf | carry-out of the ACC_W-bit add. cnt<=cnt-1.
  - A transfer with cnt==1 moves to HOLD. Without in_valid, state holds and there is no timeout.
- HOLD:
  - out_valid=1; out_sum=acc and out_ovf=ovf, stable while waiting.
  - On out_ready=1: go to IDLE.
  - out_valid rises the cycle after the last accepted product, giving 1-cycle result latency.
- out_sum and out_ovf are registered and retain their last value in IDLE. Only reset or a new start clears them.
- start is ignored outside IDLE. start in the same cycle HOLD exits is also ignored, because the state is not yet IDLE.
- Back-to-back throughput: one product per cycle in ACC. Burst overhead is 1 cycle for start plus 1+ cycles in HOLD.
- Arithmetic is unsigned only, with no saturation; wrap plus sticky flag.
- With default params the maximum sum is 15*225=3375, which fits in 12 bits, so ovf is only reachable with a narrower ACC_W.

Decomposition:
- Shared package `mult_pkg` holds:
  - State encoding constants ST_IDLE=2'd0, ST_ACC=2'd1, ST_HOLD=2'd2.
  - PROD_W default, shared with the multiplier.
- No sub-module. The adder is an inline ACC_W+1-bit add; the FSM, counter and accumulator live in one module.

Test Plan:
- Reset then idle: hold rst 2 cycles, then start=0 for 5 cycles -> in_ready=0, out_valid=0, busy=0, out_sum=0.
- Burst len=3 with products 15, 100, 225, in_valid continuous -> in_ready high 3 cycles; out_valid next cycle; out_sum=340; out_ovf=0.
- Backpressure and bubbles: len=4, in_valid toggling 1/0, products 1, 2, 3, 4, out_ready held low 3 cycles -> out_sum=10 held stable while out_valid=1; IDLE the cycle after out_ready=1.
- Empty burst: start with len=0 -> out_valid the next cycle, out_sum=0, in_ready never asserted.
- Overflow (ACC_W=10): len=5, each product 225 -> out_sum=1125-1024=101, out_ovf=1.
- Reset mid-burst: len=5, 2 products accepted, then rst=1 -> next cycle IDLE, out_sum=0. A new burst len=1 with product 7 -> out_sum=7, out_ovf=0. A start asserted during ACC is ignored and cnt is not reloaded.
